// File: rtl/jk_count_driver.sv
// Excitation stage for a bank of JK flops forming a modulo-N up/down counter with load.
// Keeps a shadow count, a sticky feedback-mismatch flag and a registered wrap pulse.
module jk_count_driver #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             up_dn_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] q_fb_i,
   output logic [WIDTH-1:0] j_o,
   output logic [WIDTH-1:0] k_o,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             mismatch_o
);

   localparam int CW = WIDTH + 1;
   localparam logic [CW-1:0] MOD_X = CW'(MODULUS);
   localparam logic [CW-1:0] TOP_X = CW'(MODULUS - 1);

   logic [CW-1:0]    cur_x;
   logic [CW-1:0]    ldv_x;
   logic [CW-1:0]    nxt_x;
   logic [WIDTH-1:0] count_d;
   logic             tc_d;

   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             mismatch_q;
   logic             chk_valid_q;

   // Widened by one bit so MODULUS == 2**WIDTH compares and wraps correctly.
   always_comb begin
      cur_x = {1'b0, q_fb_i};
      ldv_x = {1'b0, load_val_i};
      nxt_x = cur_x;
      tc_d  = 1'b0;
      if (load_i) begin
         nxt_x = (ldv_x < MOD_X) ? ldv_x : '0;
      end else if (cur_x >= MOD_X) begin
         nxt_x = '0;
      end else if (en_i) begin
         if (up_dn_i) begin
            if (cur_x == TOP_X) begin
               nxt_x = '0;
               tc_d  = 1'b1;
            end else begin
               nxt_x = cur_x + 1'b1;
            end
         end else begin
            if (cur_x == '0) begin
               nxt_x = TOP_X;
               tc_d  = 1'b1;
            end else begin
               nxt_x = cur_x - 1'b1;
            end
         end
      end
      count_d = nxt_x[WIDTH-1:0];
   end

   // Set/reset excitation only; the toggle code is never produced.
   always_comb begin
      if (rst_i) begin
         j_o = '0;
         k_o = '1;
      end else begin
         j_o = count_d & ~q_fb_i;
         k_o = ~count_d & q_fb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q     <= '0;
         tc_q        <= 1'b0;
         mismatch_q  <= 1'b0;
         chk_valid_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         tc_q        <= tc_d;
         chk_valid_q <= 1'b1;
         if (chk_valid_q && (q_fb_i != count_q)) begin
            mismatch_q <= 1'b1;
         end
      end
   end

   assign count_o    = count_q;
   assign tc_o       = tc_q;
   assign mismatch_o = mismatch_q;

endmodule

// File: tb/tb_jk_count_driver.sv
// Bench for jk_count_driver: two instances (modulus 8 and 6) each driving a JK flop model,
// checked every cycle against a modular-arithmetic reference of the counter.
module tb_jk_count_driver;

   localparam int W = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_s[2];
   logic           en_s[2];
   logic           up_s[2];
   logic           ld_s[2];
   logic [W-1:0]   lv_s[2];
   logic [W-1:0]   q_s[2];
   logic [W-1:0]   j_w[2];
   logic [W-1:0]   k_w[2];
   logic [W-1:0]   cnt_w[2];
   logic           tc_w[2];
   logic           mm_w[2];
   logic           frc_pend[2];
   logic [W-1:0]   frc_val[2];

   int mods[2] = '{8, 6};
   int m_cnt[2];
   int m_tc[2];
   int m_mm[2];
   int m_chk[2];

   int total = 0;
   int bad   = 0;

   jk_count_driver #(.WIDTH(W), .MODULUS(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst_s[0]), .en_i(en_s[0]), .up_dn_i(up_s[0]),
      .load_i(ld_s[0]), .load_val_i(lv_s[0]), .q_fb_i(q_s[0]),
      .j_o(j_w[0]), .k_o(k_w[0]), .count_o(cnt_w[0]), .tc_o(tc_w[0]),
      .mismatch_o(mm_w[0])
   );

   jk_count_driver #(.WIDTH(W), .MODULUS(6)) u_dut6 (
      .clk_i(clk), .rst_i(rst_s[1]), .en_i(en_s[1]), .up_dn_i(up_s[1]),
      .load_i(ld_s[1]), .load_val_i(lv_s[1]), .q_fb_i(q_s[1]),
      .j_o(j_w[1]), .k_o(k_w[1]), .count_o(cnt_w[1]), .tc_o(tc_w[1]),
      .mismatch_o(mm_w[1])
   );

   // Behavioural JK flops; a pending force overrides them for one edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (frc_pend[i]) begin
            q_s[i] <= frc_val[i];
         end else begin
            for (int b = 0; b < W; b++) begin
               case ({j_w[i][b], k_w[i][b]})
                  2'b10:   q_s[i][b] <= 1'b1;
                  2'b01:   q_s[i][b] <= 1'b0;
                  2'b11:   q_s[i][b] <= ~q_s[i][b];
                  default: q_s[i][b] <= q_s[i][b];
               endcase
            end
         end
      end
   end

   task automatic chk(input string tag, input int i, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[inst%0d] t=%0t observed=%0d expected=%0d", tag, i, $time, obs, exp);
      end
   endtask

   task automatic setin(input int i, input logic r, input logic e, input logic u,
                        input logic l, input logic [W-1:0] v);
      rst_s[i] = r;
      en_s[i]  = e;
      up_s[i]  = u;
      ld_s[i]  = l;
      lv_s[i]  = v;
   endtask

   task automatic force_q(input int i, input logic [W-1:0] v);
      frc_pend[i] = 1'b1;
      frc_val[i]  = v;
   endtask

   // One clock for both instances: predict, check excitation, clock, check registers.
   task automatic step();
      int nxt[2];
      int wrap[2];
      int forced[2];
      #2;
      for (int i = 0; i < 2; i++) begin
         int cur;
         int md;
         logic [W-1:0] cb, nb, ej, ek;
         md      = mods[i];
         cur     = int'(q_s[i]);
         wrap[i] = 0;
         if (rst_s[i]) begin
            nxt[i] = 0;
            ej = '0;
            ek = '1;
         end else begin
            if (ld_s[i])                nxt[i] = (int'(lv_s[i]) < md) ? int'(lv_s[i]) : 0;
            else if (cur >= md)         nxt[i] = 0;
            else if (en_s[i] && up_s[i]) begin
               nxt[i]  = (cur + 1) % md;
               wrap[i] = (cur == md - 1) ? 1 : 0;
            end else if (en_s[i]) begin
               nxt[i]  = (cur + md - 1) % md;
               wrap[i] = (cur == 0) ? 1 : 0;
            end else                    nxt[i] = cur;
            cb = W'(cur);
            nb = W'(nxt[i]);
            for (int b = 0; b < W; b++) begin
               ej[b] = (!cb[b] && nb[b]);
               ek[b] = (cb[b] && !nb[b]);
            end
         end
         chk("j", i, int'(j_w[i]), int'(ej));
         chk("k", i, int'(k_w[i]), int'(ek));
         chk("no_toggle", i, int'(j_w[i] & k_w[i]), 0);
         if (rst_s[i]) m_mm[i] = 0;
         else if (m_chk[i] != 0 && cur != m_cnt[i]) m_mm[i] = 1;
         forced[i] = frc_pend[i] ? 1 : 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         frc_pend[i] = 1'b0;
         m_cnt[i] = nxt[i];
         m_tc[i]  = wrap[i];
         m_chk[i] = rst_s[i] ? 0 : 1;
         chk("count", i, int'(cnt_w[i]), m_cnt[i]);
         chk("tc", i, int'(tc_w[i]), m_tc[i]);
         chk("mismatch", i, int'(mm_w[i]), m_mm[i]);
         if (forced[i] == 0) chk("flops", i, int'(q_s[i]), m_cnt[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         frc_pend[i] = 1'b0;
         frc_val[i]  = '0;
         m_cnt[i] = 0; m_tc[i] = 0; m_mm[i] = 0; m_chk[i] = 0;
         setin(i, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      end
      step();
      step();

      // inst0 counts up through the 7->0 wrap; inst1 counts down through the 0->5 wrap
      setin(0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      setin(1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      for (int n = 0; n < 10; n++) step();

      // load vs enable, and out-of-range load
      setin(0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
      setin(1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
      step();
      setin(0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd6);
      setin(1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
      step();
      setin(0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
      setin(1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
      step();

      // hold at 4
      setin(0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4);
      setin(1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
      step();
      setin(0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
      setin(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
      for (int n = 0; n < 5; n++) step();

      // inst0: flops disturbed to 5 while shadow is 2; inst1: illegal state 7
      setin(0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
      step();
      setin(0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
      force_q(0, 3'd5);
      force_q(1, 3'd7);
      step();
      setin(0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      setin(1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      for (int n = 0; n < 4; n++) step();
      setin(0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      step();

      // inst1: reset while a wrap is pending at 5
      setin(0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      setin(1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
      step();
      setin(1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
      step();
      setin(1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
      step();

      // randomized traffic with occasional resets and flop disturbances
      for (int n = 0; n < 120; n++) begin
         for (int i = 0; i < 2; i++) begin
            setin(i, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 6) == 0),
                  W'($urandom_range(0, 7)));
            if ($urandom_range(0, 19) == 0) force_q(i, W'($urandom_range(0, 7)));
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
